// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_ctrl : sequencing, load-use hazard and flush control for the
//                        5-stage pipeline front end, with perf counters.
// Revision 1.0
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             exMemRead,
  input  logic [4:0]       exRd,
  input  logic [4:0]       idRs1,
  input  logic [4:0]       idRs2,
  input  logic             idUsesRs2,
  input  logic             branchTaken,
  input  logic             jump,
  input  logic             endProgram,
  output logic             pcSelect,
  output logic             stall,
  output logic             flushIf,
  output logic             idBubble,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] cycleCount,
  output logic [CNT_W-1:0] stallCount
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BOOT   = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  localparam logic [3:0]       DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic in_run;
  logic hz;
  logic flush;

  assign in_run = (state_q == S_RUN);
  assign hz     = in_run & exMemRead & (exRd != 5'd0) &
                  ((exRd == idRs1) | (idUsesRs2 & (exRd == idRs2)));
  // A stalled branch/jump is not acted on; it re-resolves once the load clears.
  assign flush  = in_run & (branchTaken | jump) & ~hz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      drain_q     <= 4'd0;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_BOOT;
      S_BOOT:   state_d = S_RUN;
      S_RUN: begin
        // A halt seen alongside a flush is wrong-path; alongside hz it is re-seen next cycle.
        if (endProgram & ~flush & ~hz) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        if (drain_q == 4'd0) state_d = S_HALTED;
        else                 drain_d = drain_q - 4'd1;
      end
      S_HALTED: if (start) state_d = S_BOOT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if ((in_run || state_q == S_DRAIN) && cycle_cnt_q != CNT_MAX)
      cycle_cnt_d = cycle_cnt_q + CNT_ONE;
    if (hz && stall_cnt_q != CNT_MAX)
      stall_cnt_d = stall_cnt_q + CNT_ONE;
  end

  always_comb begin
    pcSelect = 1'b0;
    stall    = 1'b0;
    flushIf  = 1'b0;
    idBubble = 1'b0;
    running  = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_IDLE: begin
        pcSelect = 1'b1;
        stall    = 1'b1;
      end
      S_BOOT: begin
        pcSelect = 1'b1;
        running  = 1'b1;
      end
      S_RUN: begin
        stall    = hz;
        idBubble = hz;
        flushIf  = flush;
        running  = 1'b1;
      end
      S_DRAIN: begin
        stall    = 1'b1;
        idBubble = 1'b1;
        running  = 1'b1;
      end
      S_HALTED: begin
        stall    = 1'b1;
        halted   = 1'b1;
      end
      default: begin
        pcSelect = 1'b1;
        stall    = 1'b1;
      end
    endcase
  end

  assign cycleCount = cycle_cnt_q;
  assign stallCount = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipeline_hazard_ctrl : directed self-checking bench for pipeline_hazard_ctrl
// Revision 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        exMemRead;
  logic [4:0]  exRd;
  logic [4:0]  idRs1;
  logic [4:0]  idRs2;
  logic        idUsesRs2;
  logic        branchTaken;
  logic        jump;
  logic        endProgram;
  logic        pcSelect, stall, flushIf, idBubble, running, halted;
  logic [15:0] cycleCount, stallCount;
  logic        s_pcSelect, s_stall, s_flushIf, s_idBubble, s_running, s_halted;
  logic [3:0]  s_cycleCount, s_stallCount;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exMemRead(exMemRead), .exRd(exRd),
    .idRs1(idRs1), .idRs2(idRs2), .idUsesRs2(idUsesRs2), .branchTaken(branchTaken),
    .jump(jump), .endProgram(endProgram), .pcSelect(pcSelect), .stall(stall),
    .flushIf(flushIf), .idBubble(idBubble), .running(running), .halted(halted),
    .cycleCount(cycleCount), .stallCount(stallCount)
  );

  // Narrow-counter instance shares all stimulus; used for saturation checks.
  pipeline_hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(4)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .start(start), .exMemRead(exMemRead), .exRd(exRd),
    .idRs1(idRs1), .idRs2(idRs2), .idUsesRs2(idUsesRs2), .branchTaken(branchTaken),
    .jump(jump), .endProgram(endProgram), .pcSelect(s_pcSelect), .stall(s_stall),
    .flushIf(s_flushIf), .idBubble(s_idBubble), .running(s_running), .halted(s_halted),
    .cycleCount(s_cycleCount), .stallCount(s_stallCount)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; exMemRead = 0; exRd = 0; idRs1 = 0; idRs2 = 0;
    idUsesRs2 = 0; branchTaken = 0; jump = 0; endProgram = 0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic uses2);
    exMemRead = 1; exRd = rd; idRs1 = rs1; idRs2 = rs2; idUsesRs2 = uses2;
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    repeat (2) next_cycle();
    #1;
    chk("idle_pcsel",   pcSelect, 1);
    chk("idle_stall",   stall, 1);
    chk("idle_running", running, 0);
    chk("idle_halted",  halted, 0);
    chk("idle_cc",      cycleCount, 0);
    chk("idle_sc",      stallCount, 0);
    rst_n = 1;

    next_cycle();
    start = 1;
    #1 chk("idle_hold_pcsel", pcSelect, 1);
    next_cycle();
    start = 0;
    #1;
    chk("boot_pcsel",   pcSelect, 1);
    chk("boot_stall",   stall, 0);
    chk("boot_running", running, 1);

    // C0: load-use via rs2
    next_cycle();
    set_load(5'd5, 5'd0, 5'd5, 1'b1);
    #1;
    chk("run_pcsel",    pcSelect, 0);
    chk("run_halted",   halted, 0);
    chk("run_cc0",      cycleCount, 0);
    chk("hz_rs2_stall", stall, 1);
    chk("hz_rs2_bub",   idBubble, 1);

    // C1: load to x0 never hazards
    next_cycle();
    set_load(5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    chk("hz_x0_stall", stall, 0);
    chk("hz_x0_bub",   idBubble, 0);
    chk("sc_after_1",  stallCount, 1);
    chk("cc_c1",       cycleCount, 1);

    // C2: load-use via rs1
    next_cycle();
    set_load(5'd7, 5'd7, 5'd0, 1'b0);
    #1 chk("hz_rs1_stall", stall, 1);

    // C3: rs2 match but rs2 not read
    next_cycle();
    set_load(5'd9, 5'd1, 5'd9, 1'b0);
    #1;
    chk("hz_nors2_stall", stall, 0);
    chk("sc_after_2",     stallCount, 2);

    // C4: branch suppressed by hazard
    next_cycle();
    set_load(5'd3, 5'd3, 5'd0, 1'b0);
    branchTaken = 1;
    #1;
    chk("br_hz_flush", flushIf, 0);
    chk("br_hz_stall", stall, 1);

    // C5: branch re-resolves
    next_cycle();
    exMemRead = 0;
    #1;
    chk("br_flush",  flushIf, 1);
    chk("br_stall",  stall, 0);
    chk("sc_after_3", stallCount, 3);

    // C6: halt on wrong path behind a jump
    next_cycle();
    branchTaken = 0; jump = 1; endProgram = 1;
    #1 chk("jmp_end_flush", flushIf, 1);

    // C7: halt coinciding with a hazard
    next_cycle();
    jump = 0;
    set_load(5'd3, 5'd3, 5'd0, 1'b0);
    #1;
    chk("end_wrongpath_running", running, 1);
    chk("end_wrongpath_pcsel",   pcSelect, 0);
    chk("end_hz_stall",          stall, 1);
    chk("end_hz_flush",          flushIf, 0);

    // C8: halt accepted
    next_cycle();
    exMemRead = 0;
    #1;
    chk("end_hz_stay_bub", idBubble, 0);
    chk("cc_c8",           cycleCount, 8);

    for (int i = 0; i < 4; i++) begin
      next_cycle();
      endProgram = 0;
      #1;
      chk("drain_stall",   stall, 1);
      chk("drain_bub",     idBubble, 1);
      chk("drain_running", running, 1);
      chk("drain_halted",  halted, 0);
    end

    next_cycle();
    #1;
    chk("halt_halted",  halted, 1);
    chk("halt_running", running, 0);
    chk("halt_stall",   stall, 1);
    chk("halt_cc",      cycleCount, 13);
    chk("halt_sc",      stallCount, 4);
    next_cycle();
    #1 chk("halt_cc_hold", cycleCount, 13);

    // Restart from HALTED keeps counters
    start = 1;
    next_cycle();
    start = 0;
    #1;
    chk("reboot_pcsel", pcSelect, 1);
    chk("reboot_cc",    cycleCount, 13);
    next_cycle();
    #1 chk("rerun_pcsel", pcSelect, 0);
    endProgram = 1;
    next_cycle();
    endProgram = 0;
    start = 1;
    #1 chk("drain2_bub", idBubble, 1);
    next_cycle();
    start = 0;
    #1 chk("drain2_start_ignored", idBubble, 1);

    // Asynchronous reset mid-DRAIN
    #1 rst_n = 0;
    #1;
    chk("arst_pcsel",  pcSelect, 1);
    chk("arst_stall",  stall, 1);
    chk("arst_halted", halted, 0);
    chk("arst_bub",    idBubble, 0);
    chk("arst_cc",     cycleCount, 0);
    next_cycle();
    rst_n = 1;
    next_cycle();
    start = 1;
    next_cycle();
    start = 0;
    #1;
    chk("rst_boot_pcsel",   pcSelect, 1);
    chk("rst_boot_running", running, 1);
    next_cycle();
    #1 chk("rst_run_pcsel", pcSelect, 0);

    // Hazard held for 20 RUN cycles
    set_load(5'd4, 5'd4, 5'd0, 1'b0);
    repeat (20) next_cycle();
    exMemRead = 0;
    #1;
    chk("sat_sc_small", s_stallCount, 15);
    chk("sat_cc_small", s_cycleCount, 15);
    chk("sat_sc_wide",  stallCount, 20);
    chk("sat_cc_wide",  cycleCount, 20);
    next_cycle();
    #1 chk("sat_sc_small_hold", s_stallCount, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
